// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus send sequencer that feeds the UART transmitter.
// Bytes from the UART TX store path are queued here. They are then sent one at a
// time with a single-cycle send pulse, and the sequencer waits on uart_busy.
// Optional build macro: UART_TX_OVERFLOW_FLAG_EN adds a sticky overflow flag (status bit 3).
module uart_tx_buffer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     uart_busy,
  output logic [7:0]               uart_tx_data,
  output logic                     uart_tx_send,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              status_rddata
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StWaitHi, StWaitLo} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      tx_data_q;
  logic            tx_send_q;
  logic            push, pop;
  logic            overflow;
  logic            tx_active;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // full is the pre-edge value, so a push while full is dropped even if a pop lands.
  assign push  = wr_en && !full && !flush;
  assign pop   = (state_q == StIdle) && !empty && !uart_busy && !flush;

  // Storage array; no reset, stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (n_rst && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers and occupancy; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Sequencer next state: pop in idle, pulse, then wait for busy to rise and fall.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StSend;
      end
      StSend: begin
        tmo_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        // A UART that never raises busy must not stall the queue forever.
        if (uart_busy) begin
          state_d = StWaitLo;
        end else if (tmo_q == TmoW'(BUSY_TIMEOUT - 1)) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWaitLo: begin
        if (!uart_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer registers; the send pulse is registered so it is glitch-free.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      tx_data_q <= 8'h00;
      tx_send_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      tx_send_q <= (state_d == StSend);
      if (pop) tx_data_q <= mem_q[rd_ptr_q];
    end
  end

`ifdef UART_TX_OVERFLOW_FLAG_EN
  logic ovf_q;

  // Sticky record of a dropped push; flush clears it even if set in the same cycle.
  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      ovf_q <= 1'b0;
    end else if (wr_en && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign tx_active     = (state_q != StIdle);
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_send  = tx_send_q;
  assign count         = count_q;
  assign status_rddata = {16'h0000, 8'(count_q), 4'h0, overflow, tx_active, full, empty};

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a byte scoreboard and a simple UART busy model.
module tb_uart_tx_buffer;

`ifdef UART_TX_OVERFLOW_FLAG_EN
  localparam logic OvfExp = 1'b1;
`else
  localparam logic OvfExp = 1'b0;
`endif
  localparam int TmoGap = 8 + 2;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        uart_busy;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_send;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic [31:0] status_rddata;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          send_cnt = 0;
  int          last_cyc = 0;
  int          last_gap = 0;
  logic [7:0]  sb[$];

  // UART model: busy rises a few cycles after a send pulse and stays for m_len cycles.
  logic        model_en = 1'b0;
  logic        force_busy = 1'b0;
  int          m_len = 20;
  int          m_cnt = 0;
  logic        model_busy;

  uart_tx_buffer #(.DEPTH(16), .BUSY_TIMEOUT(8)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .flush         (flush),
    .uart_busy     (uart_busy),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_send  (uart_tx_send),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .status_rddata (status_rddata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (uart_tx_send === 1'b1) begin
      m_cnt <= 1;
    end else if (m_cnt != 0) begin
      m_cnt <= (m_cnt >= 2 + m_len) ? 0 : m_cnt + 1;
    end
  end

  assign model_busy = (m_cnt >= 3) && (m_cnt < 3 + m_len);
  assign uart_busy  = model_en ? model_busy : force_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every send pulse must carry the oldest byte still owed by the scoreboard.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && uart_tx_send === 1'b1) begin
      send_cnt++;
      last_gap = cyc - last_cyc;
      last_cyc = cyc;
      if (sb.size() == 0) check("unexpected_send", {31'h0, uart_tx_send}, 32'h0);
      else check("tx_order", {24'h0, uart_tx_data}, {24'h0, sb.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
    if (acc) sb.push_back(b);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int i = 0;
    while (status_rddata[2] && i < bound) begin
      step();
      i++;
    end
    check(tag, {31'h0, status_rddata[2]}, 32'h0);
  endtask

  task automatic wait_sends(input int target, input int bound, input string tag);
    int i = 0;
    while (send_cnt < target && i < bound) begin
      step();
      i++;
    end
    check(tag, send_cnt, target);
  endtask

  initial begin
    n_rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;

    // Reset then idle
    step(); step();
    check("rst_empty", {31'h0, empty}, 32'h1);
    check("rst_full", {31'h0, full}, 32'h0);
    check("rst_count", {27'h0, count}, 32'h0);
    check("rst_send", {31'h0, uart_tx_send}, 32'h0);
    check("rst_data", {24'h0, uart_tx_data}, 32'h0);
    check("rst_status", status_rddata, 32'h1);
    n_rst = 1'b1;
    step();

    // Single byte: pop one edge after the push, pulse in the following cycle
    m_len = 20; model_en = 1'b1;
    push(8'h41, 1'b1);
    check("single_count1", {27'h0, count}, 32'h1);
    check("single_send_early", {31'h0, uart_tx_send}, 32'h0);
    step();
    check("single_send", {31'h0, uart_tx_send}, 32'h1);
    check("single_data", {24'h0, uart_tx_data}, 32'h41);
    check("single_empty", {31'h0, empty}, 32'h1);
    step();
    check("single_send_once", {31'h0, uart_tx_send}, 32'h0);
    check("single_active", {31'h0, status_rddata[2]}, 32'h1);
    wait_idle(60, "single_idle");
    check("single_sends", send_cnt, 1);
    check("single_data_hold", {24'h0, uart_tx_data}, 32'h41);

    // Burst fill while the UART is busy
    force_busy = 1'b1; model_en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b1);
    check("burst_full", {31'h0, full}, 32'h1);
    check("burst_count", {27'h0, count}, 32'd16);
    check("burst_status_cnt", {24'h0, status_rddata[15:8]}, 32'd16);
    check("burst_status_full", {30'h0, status_rddata[1:0]}, 32'h2);

    // Overflow: push while full is dropped
    push(8'hAA, 1'b0);
    check("ovf_count", {27'h0, count}, 32'd16);
    check("ovf_flag", {31'h0, status_rddata[3]}, {31'h0, OvfExp});

    // Drain with the UART model; order checked by the scoreboard
    m_len = 3; model_en = 1'b1;
    wait_sends(17, 400, "burst_sends");
    wait_idle(60, "burst_idle");
    check("burst_drained", {27'h0, count}, 32'h0);
    check("burst_sb_empty", sb.size(), 0);
    check("ovf_sticky", {31'h0, status_rddata[3]}, {31'h0, OvfExp});

    // Busy timeout: UART never raises busy; simultaneous push and pop on the 2nd push
    model_en = 1'b0; force_busy = 1'b0;
    push(8'hB0, 1'b1);
    push(8'hB1, 1'b1);
    check("pushpop_count", {27'h0, count}, 32'h1);
    wait_sends(19, 60, "tmo_sends");
    check("tmo_gap", last_gap, TmoGap);
    wait_idle(30, "tmo_idle");

    // Flush with one byte in flight and five queued; concurrent push discarded
    m_len = 20; model_en = 1'b1;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i), 1'b1);
    step(); step();
    check("flush_pre_count", {27'h0, count}, 32'd5);
    check("flush_pre_active", {31'h0, status_rddata[2]}, 32'h1);
    check("flush_pre_ovf", {31'h0, status_rddata[3]}, {31'h0, OvfExp});
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    step();
    flush = 1'b0; wr_en = 1'b0;
    sb.delete();
    check("flush_count", {27'h0, count}, 32'h0);
    check("flush_empty", {31'h0, empty}, 32'h1);
    check("flush_active", {31'h0, status_rddata[2]}, 32'h1);
    check("flush_data", {24'h0, uart_tx_data}, 32'hC0);
    check("flush_ovf_clr", {31'h0, status_rddata[3]}, 32'h0);
    wait_idle(60, "flush_idle");
    for (int i = 0; i < 10; i++) step();
    check("flush_no_more_sends", send_cnt, 20);

    // Same scenario, reset instead of flush
    for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i), 1'b1);
    step(); step();
    check("rst2_pre_active", {31'h0, status_rddata[2]}, 32'h1);
    n_rst = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    step();
    check("rst2_send", {31'h0, uart_tx_send}, 32'h0);
    check("rst2_data", {24'h0, uart_tx_data}, 32'h0);
    check("rst2_count", {27'h0, count}, 32'h0);
    check("rst2_full", {31'h0, full}, 32'h0);
    check("rst2_status", status_rddata, 32'h1);
    n_rst = 1'b1; wr_en = 1'b0;
    sb.delete();
    for (int i = 0; i < 30; i++) step();
    check("rst2_no_more_sends", send_cnt, 21);
    check("rst2_still_empty", {31'h0, empty}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
